// File: rtl/branch_perf_monitor_if.sv
// Retire-stream bundle between the pipeline debug port and branch_perf_monitor.
// master = stream source / counter reader, slave = monitor.
interface branch_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             i_insn_vld;
  logic             i_ctrl;
  logic             i_mispred;
  logic [31:0]      i_pc_debug;
  logic             i_clear;
  logic             i_trace_rd;
  logic [CNT_W-1:0] o_cycle_cnt;
  logic [CNT_W-1:0] o_insn_cnt;
  logic [CNT_W-1:0] o_ctrl_cnt;
  logic [CNT_W-1:0] o_mispred_cnt;
  logic             o_done;
  logic             o_err;
  logic             o_trace_vld;
  logic [31:0]      o_trace_pc;
  logic             o_trace_ovf;

  modport master (
    output i_insn_vld, i_ctrl, i_mispred, i_pc_debug, i_clear, i_trace_rd,
    input  o_cycle_cnt, o_insn_cnt, o_ctrl_cnt, o_mispred_cnt,
    input  o_done, o_err, o_trace_vld, o_trace_pc, o_trace_ovf
  );

  modport slave (
    input  i_insn_vld, i_ctrl, i_mispred, i_pc_debug, i_clear, i_trace_rd,
    output o_cycle_cnt, o_insn_cnt, o_ctrl_cnt, o_mispred_cnt,
    output o_done, o_err, o_trace_vld, o_trace_pc, o_trace_ovf
  );
endinterface

// File: rtl/branch_perf_monitor.sv
// Retire-side perf counters with self-loop halt detection; all outputs registered (1-cycle latency).
// Optional mispredicted-PC trace FIFO under macro PERF_TRACE_EN; no backpressure on the retire stream.
module branch_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int HALT_CNT    = 8,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  branch_perf_monitor_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  localparam int SC_W = $clog2(HALT_CNT + 1);

  if (HALT_CNT < 2 || TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_param
    $error("branch_perf_monitor: HALT_CNT must be >=2 and TRACE_DEPTH a power of two >=2");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] insn_q, insn_d;
  logic [CNT_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [SC_W-1:0]  same_q, same_d;
  logic             err_q, err_d;
  logic             active;
  logic             retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The IDLE->RUN cycle is already a RUN cycle, so it counts like one.
  assign active = (state_q == S_RUN) || (state_q == S_IDLE && bus.i_insn_vld);
  assign retire = active && bus.i_insn_vld && !bus.i_clear;

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    insn_d    = insn_q;
    ctrl_d    = ctrl_q;
    mis_d     = mis_q;
    last_pc_d = last_pc_q;
    same_d    = same_q;
    err_d     = err_q;
    if (bus.i_clear) begin
      state_d   = S_IDLE;
      cycle_d   = '0;
      insn_d    = '0;
      ctrl_d    = '0;
      mis_d     = '0;
      last_pc_d = '0;
      same_d    = '0;
      err_d     = 1'b0;
    end else if (active) begin
      state_d = S_RUN;
      cycle_d = sat_inc(cycle_q);
      if (bus.i_insn_vld) begin
        insn_d = sat_inc(insn_q);
        if (bus.i_ctrl)    ctrl_d = sat_inc(ctrl_q);
        if (bus.i_mispred) mis_d  = sat_inc(mis_q);
        if (bus.i_mispred && !bus.i_ctrl) err_d = 1'b1;
        same_d    = (bus.i_pc_debug == last_pc_q) ? same_q + SC_W'(1) : SC_W'(1);
        last_pc_d = bus.i_pc_debug;
        if (same_d == SC_W'(HALT_CNT)) state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      cycle_q   <= '0;
      insn_q    <= '0;
      ctrl_q    <= '0;
      mis_q     <= '0;
      last_pc_q <= '0;
      same_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      insn_q    <= insn_d;
      ctrl_q    <= ctrl_d;
      mis_q     <= mis_d;
      last_pc_q <= last_pc_d;
      same_q    <= same_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_cycle_cnt   = cycle_q;
  assign bus.o_insn_cnt    = insn_q;
  assign bus.o_ctrl_cnt    = ctrl_q;
  assign bus.o_mispred_cnt = mis_q;
  assign bus.o_done        = (state_q == S_HALT);
  assign bus.o_err         = err_q;

`ifdef PERF_TRACE_EN
  localparam int PW = $clog2(TRACE_DEPTH);

  logic [31:0] mem_q [TRACE_DEPTH];
  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  logic        ovf_q, ovf_d;
  logic        empty, full, push, pop, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign push    = retire && bus.i_mispred;
  assign pop     = bus.i_trace_rd && !empty && (state_q != S_HALT) && !bus.i_clear;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (bus.i_clear) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (push_ok)        wr_d  = wr_q + (PW+1)'(1);
      if (pop)            rd_d  = rd_q + (PW+1)'(1);
      if (push && !push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q[PW-1:0]] <= bus.i_pc_debug;
  end

  assign bus.o_trace_vld = !empty;
  assign bus.o_trace_pc  = empty ? 32'h0 : mem_q[rd_q[PW-1:0]];
  assign bus.o_trace_ovf = ovf_q;
`else
  assign bus.o_trace_vld = 1'b0;
  assign bus.o_trace_pc  = 32'h0;
  assign bus.o_trace_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_branch_perf_monitor.sv
// Directed bench for branch_perf_monitor: main instance (CNT_W=32) plus a CNT_W=4 instance for saturation.
module tb_branch_perf_monitor;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_perf_monitor_if #(.CNT_W(32)) bus ();
  branch_perf_monitor_if #(.CNT_W(4))  bus_s ();

  branch_perf_monitor #(.CNT_W(32), .HALT_CNT(8), .TRACE_DEPTH(16)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  branch_perf_monitor #(.CNT_W(4), .HALT_CNT(8), .TRACE_DEPTH(16)) dut_s (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fail(input string tag);
    errors++;
    $error("FAIL %s", tag);
  endtask

  task automatic idle_inputs();
    bus.i_insn_vld = 0; bus.i_ctrl = 0; bus.i_mispred = 0;
    bus.i_pc_debug = 0; bus.i_clear = 0; bus.i_trace_rd = 0;
    bus_s.i_insn_vld = 0; bus_s.i_ctrl = 0; bus_s.i_mispred = 0;
    bus_s.i_pc_debug = 0; bus_s.i_clear = 0; bus_s.i_trace_rd = 0;
  endtask

  // One clock on the main instance; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input logic c, input logic m, input logic [31:0] pc,
                     input logic clr, input logic rd);
    bus.i_insn_vld = v; bus.i_ctrl = c; bus.i_mispred = m;
    bus.i_pc_debug = pc; bus.i_clear = clr; bus.i_trace_rd = rd;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic cyc_s(input logic [31:0] pc);
    bus_s.i_insn_vld = 1; bus_s.i_pc_debug = pc;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    checks++; if (bus.o_cycle_cnt !== 32'd0) fail("rst_cycle");
    checks++; if (bus.o_insn_cnt !== 32'd0) fail("rst_insn");
    checks++; if (bus.o_done !== 1'b0) fail("rst_done");
    checks++; if (bus.o_err !== 1'b0) fail("rst_err");
    checks++; if (bus.o_trace_vld !== 1'b0) fail("rst_trace_vld");
    checks++; if (bus.o_trace_pc !== 32'h0) fail("rst_trace_pc");
    checks++; if (bus.o_trace_ovf !== 1'b0) fail("rst_trace_ovf");

    repeat (5) cyc(0, 0, 0, 32'h0, 0, 0);
    checks++; if (bus.o_cycle_cnt !== 32'd0) fail("idle_cycle");

    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 32'(4 * i), 0, 0);
    checks++; if (bus.o_cycle_cnt !== 32'd10) fail("seq_cycle");
    checks++; if (bus.o_insn_cnt !== 32'd10) fail("seq_insn");
    checks++; if (bus.o_ctrl_cnt !== 32'd0) fail("seq_ctrl");
    checks++; if (bus.o_mispred_cnt !== 32'd0) fail("seq_mis");
    checks++; if (bus.o_done !== 1'b0) fail("seq_done");

    cyc(1, 1, 1, 32'h100, 0, 0);
    cyc(1, 1, 0, 32'h104, 0, 0);
    cyc(1, 1, 1, 32'h200, 0, 0);
    cyc(1, 1, 0, 32'h204, 0, 0);
    checks++; if (bus.o_cycle_cnt !== 32'd14) fail("br_cycle");
    checks++; if (bus.o_insn_cnt !== 32'd14) fail("br_insn");
    checks++; if (bus.o_ctrl_cnt !== 32'd4) fail("br_ctrl");
    checks++; if (bus.o_mispred_cnt !== 32'd2) fail("br_mis");
    checks++; if (bus.o_err !== 1'b0) fail("br_err");
`ifdef PERF_TRACE_EN
    checks++; if (bus.o_trace_pc !== 32'h100) fail("tr_head0");
    cyc(0, 0, 0, 32'h0, 0, 1);
    checks++; if (bus.o_trace_pc !== 32'h200) fail("tr_head1");
    checks++; if (bus.o_trace_vld !== 1'b1) fail("tr_vld1");
    cyc(0, 0, 0, 32'h0, 0, 1);
`else
    cyc(0, 0, 0, 32'h0, 0, 1);
    cyc(0, 0, 0, 32'h0, 0, 1);
`endif
    checks++; if (bus.o_trace_vld !== 1'b0) fail("tr_empty");
    checks++; if (bus.o_trace_pc !== 32'h0) fail("tr_pc_empty");
    checks++; if (bus.o_cycle_cnt !== 32'd16) fail("run_cycle");

    cyc(1, 0, 1, 32'h300, 0, 0);
    checks++; if (bus.o_err !== 1'b1) fail("err_set");
    checks++; if (bus.o_mispred_cnt !== 32'd3) fail("err_mis");
    checks++; if (bus.o_insn_cnt !== 32'd15) fail("err_insn");
    cyc(0, 0, 0, 32'h0, 0, 1);
    checks++; if (bus.o_trace_vld !== 1'b0) fail("err_popped");

    for (int i = 0; i < 17; i++) cyc(1, 1, 1, 32'h1000 + 32'(4 * i), 0, 0);
    checks++; if (bus.o_mispred_cnt !== 32'd20) fail("ovf_mis");
    checks++; if (bus.o_cycle_cnt !== 32'd35) fail("ovf_cycle");
`ifdef PERF_TRACE_EN
    checks++; if (bus.o_trace_ovf !== 1'b1) fail("ovf_flag");
    checks++; if (bus.o_trace_pc !== 32'h1000) fail("ovf_head");
`else
    checks++; if (bus.o_trace_ovf !== 1'b0) fail("ovf_flag_off");
    checks++; if (bus.o_trace_vld !== 1'b0) fail("ovf_vld_off");
`endif
    cyc(1, 1, 1, 32'h2000, 0, 1);
`ifdef PERF_TRACE_EN
    checks++; if (bus.o_trace_pc !== 32'h1004) fail("pp_head");
`endif
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 32'h0, 0, 1);
`ifdef PERF_TRACE_EN
    checks++; if (bus.o_trace_pc !== 32'h2000) fail("pp_tail");
    checks++; if (bus.o_trace_vld !== 1'b1) fail("pp_tail_vld");
`endif
    cyc(0, 0, 0, 32'h0, 0, 1);
    checks++; if (bus.o_trace_vld !== 1'b0) fail("pp_drained");
    checks++; if (bus.o_cycle_cnt !== 32'd52) fail("pp_cycle");
    checks++; if (bus.o_insn_cnt !== 32'd33) fail("pp_insn");

    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 32'h40, 0, 0);
    checks++; if (bus.o_done !== 1'b0) fail("halt_pre");
    cyc(1, 0, 0, 32'h40, 0, 0);
    checks++; if (bus.o_done !== 1'b1) fail("halt_done");
    checks++; if (bus.o_insn_cnt !== 32'd41) fail("halt_insn");
    cyc(1, 1, 1, 32'h40, 0, 0);
    cyc(0, 0, 0, 32'h0, 0, 0);
    checks++; if (bus.o_insn_cnt !== 32'd41) fail("halt_frz_insn");
    checks++; if (bus.o_cycle_cnt !== 32'd60) fail("halt_frz_cycle");
    checks++; if (bus.o_mispred_cnt !== 32'd21) fail("halt_frz_mis");

    cyc(1, 0, 0, 32'h44, 1, 0);
    checks++; if (bus.o_cycle_cnt !== 32'd0) fail("clr_cycle");
    checks++; if (bus.o_insn_cnt !== 32'd0) fail("clr_insn");
    checks++; if (bus.o_ctrl_cnt !== 32'd0) fail("clr_ctrl");
    checks++; if (bus.o_mispred_cnt !== 32'd0) fail("clr_mis");
    checks++; if (bus.o_done !== 1'b0) fail("clr_done");
    checks++; if (bus.o_err !== 1'b0) fail("clr_err");
    checks++; if (bus.o_trace_ovf !== 1'b0) fail("clr_ovf");

    for (int i = 0; i < 20; i++) cyc_s(32'h500 + 32'(4 * i));
    checks++; if (bus_s.o_insn_cnt !== 4'd15) fail("sat_insn");
    checks++; if (bus_s.o_cycle_cnt !== 4'd15) fail("sat_cycle");

    cyc(1, 0, 0, 32'h10, 0, 0);
    cyc(1, 0, 0, 32'h14, 0, 0);
    cyc(1, 0, 0, 32'h18, 0, 0);
    checks++; if (bus.o_insn_cnt !== 32'd3) fail("rerun_insn");
    #2;
    rst_n = 0;
    #1;
    checks++; if (bus.o_insn_cnt !== 32'd0) fail("arst_insn");
    checks++; if (bus.o_cycle_cnt !== 32'd0) fail("arst_cycle");
    checks++; if (bus_s.o_insn_cnt !== 4'd0) fail("arst_sat_insn");
    @(posedge clk); #1;
    rst_n = 1;
    cyc(0, 0, 0, 32'h0, 0, 0);
    checks++; if (bus.o_cycle_cnt !== 32'd0) fail("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_perf_monitor.md
# branch_perf_monitor

Retirement-side performance monitor that consumes the pipeline's debug retire stream (instruction-valid, control-transfer, misprediction and PC flags) and keeps cycle, instruction, control-transfer and misprediction counters for evaluating the tagged geometric predictor. It detects end-of-program: a self-loop retiring at the same PC repeatedly freezes the counters and raises a done flag for the scoreboard. It sits in the bench directly downstream of `pipelined`, in parallel with the scoreboard.

## Interface
- `CNT_W`, 32, width of every counter
- `HALT_CNT`, 8, consecutive valid retirements at an identical PC that declare halt (≥2)
- `TRACE_DEPTH`, 16, mispredicted-PC trace FIFO depth (power of two)

- `i_clk`  in  1  clock; single clock domain
- `i_reset`  in  1  asynchronous active-low reset
- `i_insn_vld`  in  1  an instruction retires this cycle
- `i_ctrl`  in  1  retiring instruction is a branch/jump (qualified by `i_insn_vld`)
- `i_mispred`  in  1  retiring instruction was mispredicted (qualified by `i_insn_vld`)
- `i_pc_debug`  in  32  PC of the retiring instruction
- `i_clear`  in  1  synchronous clear: counters, FSM, trace
- `o_cycle_cnt`  out  CNT_W  cycles spent in RUN
- `o_insn_cnt`  out  CNT_W  valid retirements
- `o_ctrl_cnt`  out  CNT_W  valid control-transfer retirements
- `o_mispred_cnt`  out  CNT_W  valid mispredicted retirements
- `o_done`  out  1  FSM is in HALT
- `o_err`  out  1  sticky: `i_mispred` seen with `i_insn_vld` and without `i_ctrl`
- `i_trace_rd`  in  1  pop trace head
- `o_trace_vld`  out  1  trace FIFO non-empty
- `o_trace_pc`  out  32  trace head PC (show-ahead)
- `o_trace_ovf`  out  1  sticky: a push was dropped

## Operation
- FSM states IDLE, RUN, HALT; reset → IDLE.
- IDLE → RUN on the first cycle with `i_insn_vld`=1. That cycle is counted as if in RUN: cycle +1, retirement counted.
- RUN: `o_cycle_cnt` +1 every cycle. On `i_insn_vld`: insn +1; ctrl +1 if `i_ctrl`; mispred +1 if `i_mispred`.
- Halt detection, valid retirements only: `i_pc_debug` == last PC → same-count +1, else same-count = 1. Last PC is updated on each valid retirement. Reaching `HALT_CNT` → HALT. The counters include that retirement.
- HALT: all counters and the trace freeze. Inputs other than `i_clear` are ignored until `i_clear` or reset.
- `i_clear`: in any state → IDLE, all counters 0, same-count 0, trace flushed, `o_err` and `o_trace_ovf` cleared. `i_clear` takes priority over every same-cycle event.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- `o_err` is set on any valid mispredicted non-ctrl retirement in IDLE or RUN. That retirement is still counted as a misprediction.

## Timing
- Reset values: all counters 0, `o_done`=0, `o_err`=0, `o_trace_vld`=0, `o_trace_pc`=0, `o_trace_ovf`=0.
- All outputs are registered. An event in cycle N is visible in cycle N+1.
- `o_done` rises in the cycle after the `HALT_CNT`-th matching retirement.
- Reset asserted mid-run clears all state immediately (asynchronously). Counting restarts only after the next IDLE → RUN transition.

## Configuration
- Macro `PERF_TRACE_EN`:
  - Defined: the FIFO is compiled in. A valid mispredicted retirement in IDLE→RUN or RUN pushes `i_pc_debug`. `i_trace_rd` with `o_trace_vld`=1 pops the head; a pop when empty is ignored.
  - Push while full is dropped and sets `o_trace_ovf`. Simultaneous push and pop while full succeeds, with no overflow.
  - Undefined: no FIFO storage. `o_trace_vld`, `o_trace_pc` and `o_trace_ovf` are tied 0, and `i_trace_rd` is ignored.

## Test plan
- Reset, 5 idle cycles, then 10 consecutive valid non-ctrl retirements at PCs 0x0, 0x4, … 0x24 → cycle=10, insn=10, ctrl=0, mispred=0, `o_done`=0.
- 4 ctrl retirements, 2 of them mispredicted at PCs 0x100 and 0x200 (`PERF_TRACE_EN`) → ctrl=4, mispred=2. Trace pops yield 0x100 then 0x200, after which `o_trace_vld`=0.
- Retire PC 0x40 eight times in succession (HALT_CNT=8) → `o_done`=1 the cycle after the 8th. Further retirements leave insn unchanged.
- With `TRACE_DEPTH`=16, issue 17 mispredicted retirements without reads → 16 entries held, `o_trace_ovf`=1. Repeat when full with simultaneous `i_trace_rd` → no drop.
- Valid retirement with `i_mispred`=1, `i_ctrl`=0 → `o_err`=1, mispred +1. Assert `i_clear` in HALT → all counters 0, `o_done`=0, `o_err`=0.
- Preload insn counter near saturation (CNT_W=4, 20 retirements) → insn holds at 15. Assert `i_reset` mid-run → all outputs 0 immediately.
